// File: rtl/interrupt_arbiter.sv
// -----------------------------------------------------------------------------
// interrupt_arbiter
//
// Interrupt capture and arbitration for the 6502C control path. Each active-low
// interrupt line is synchronised, then captured either as a falling edge
// (latched until acknowledged) or as a level (follows the line). Eligible
// pending channels are arbitrated by fixed priority (channel 0 highest) and a
// single winner is presented until the control logic acknowledges it.
//
// Ports:
//   phi1        in   1       sole clock, rising edge
//   rstAll      in   1       asynchronous active-high reset
//   intIn_L     in   NUM_CH  raw active-low interrupt lines
//   maskEn      in   NUM_CH  1 = channel may be presented (ignored for NOMASK)
//   intHandled  in   1       acknowledge of the presented channel
//   clrOverrun  in   1       pulse: clear all overrun flags
//   activeInt   out  IDX_W   winning channel index + 1, 0 = none
//   intValid    out  1       high while activeInt is nonzero
//   pending     out  NUM_CH  registered pending vector
//   overrun     out  NUM_CH  sticky: edge arrived while already pending
//
// Constraints: 2**IDX_W >= NUM_CH+1, 1 <= SYNC_STAGES <= 3.
// -----------------------------------------------------------------------------
module interrupt_arbiter #(
  parameter int unsigned       NUM_CH      = 3,
  parameter int unsigned       IDX_W       = 2,
  parameter logic [NUM_CH-1:0] EDGE_MASK   = 3'b010,
  parameter logic [NUM_CH-1:0] NOMASK      = 3'b011,
  parameter int unsigned       SYNC_STAGES = 2
) (
  input  logic              phi1,
  input  logic              rstAll,
  input  logic [NUM_CH-1:0] intIn_L,
  input  logic [NUM_CH-1:0] maskEn,
  input  logic              intHandled,
  input  logic              clrOverrun,
  output logic [IDX_W-1:0]  activeInt,
  output logic              intValid,
  output logic [NUM_CH-1:0] pending,
  output logic [NUM_CH-1:0] overrun
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t                           state_q;
  state_t                           state_d;
  logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_q;
  logic [NUM_CH-1:0]                sync;
  logic [NUM_CH-1:0]                prev_q;
  logic [NUM_CH-1:0]                fall;
  logic [NUM_CH-1:0]                clr;
  logic [NUM_CH-1:0]                eligible;
  logic [NUM_CH-1:0]                pending_d;
  logic [NUM_CH-1:0]                overrun_d;
  logic [IDX_W-1:0]                 active_d;
  logic                             valid_d;

  // ---------------------------------------------------------------------------
  // Synchroniser and edge history
  // ---------------------------------------------------------------------------
  // NOTE: the synchroniser array is reset to the idle (high) level so a line
  // that is quiet across reset never looks like a falling edge afterwards.
  always_ff @(posedge phi1 or posedge rstAll) begin
    if (rstAll) begin
      sync_q <= '1;
      prev_q <= '1;
    end else begin
      // NOTE: non-blocking assignments let every stage sample the previous
      // stage's old value, forming a true shift chain.
      sync_q[0] <= intIn_L;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      prev_q <= sync;
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];
  assign fall = prev_q & ~sync & EDGE_MASK;

  // ---------------------------------------------------------------------------
  // Pending / overrun next-state
  // ---------------------------------------------------------------------------
  // Acknowledge decodes to the channel currently being presented.
  always_comb begin
    // NOTE: default first so no path leaves clr unassigned (no latch).
    clr = '0;
    if (state_q == ACTIVE && intHandled) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (activeInt == IDX_W'(k + 1)) begin
          clr[k] = 1'b1;
        end
      end
    end
  end

  // Edge channels: a new fall outranks a simultaneous acknowledge.
  // Level channels: simply mirror the synchronised line.
  assign pending_d = (EDGE_MASK & (fall | (pending & ~clr)))
                   | (~EDGE_MASK & ~sync);

  // A fall on an already-pending channel is an overrun unless that pending
  // bit is being consumed this same cycle. Setting outranks clrOverrun.
  assign overrun_d = (fall & pending & ~clr)
                   | (overrun & ~{NUM_CH{clrOverrun}});

  assign eligible = pending & (maskEn | NOMASK);

  // ---------------------------------------------------------------------------
  // Grant state machine
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    active_d = activeInt;
    valid_d  = intValid;
    case (state_q)
      IDLE: begin
        active_d = '0;
        valid_d  = 1'b0;
        if (|eligible) begin
          // Scan downward so the lowest set index is the final assignment.
          for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (eligible[k]) begin
              active_d = IDX_W'(k + 1);
            end
          end
          valid_d = 1'b1;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        // Grant is frozen: no preemption, and it survives the line or mask
        // going away. Only the acknowledge releases it, and the following
        // IDLE cycle guarantees intValid drops between grants.
        if (intHandled) begin
          active_d = '0;
          valid_d  = 1'b0;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d  = IDLE;
        active_d = '0;
        valid_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge phi1 or posedge rstAll) begin
    if (rstAll) begin
      state_q   <= IDLE;
      activeInt <= '0;
      intValid  <= 1'b0;
      pending   <= '0;
      overrun   <= '0;
    end else begin
      state_q   <= state_d;
      activeInt <= active_d;
      intValid  <= valid_d;
      pending   <= pending_d;
      overrun   <= overrun_d;
    end
  end

endmodule

// File: tb/tb_interrupt_arbiter.sv
// -----------------------------------------------------------------------------
// tb_interrupt_arbiter
//
// Directed bench for interrupt_arbiter with default parameters (ch0 level
// non-maskable, ch1 edge non-maskable, ch2 level maskable, 2 sync stages).
// Expected grants are queued by the stimulus; a monitor pops one on every
// rising intValid and compares activeInt. Pending/overrun/timing are checked
// directly at hand-computed edges.
// -----------------------------------------------------------------------------
module tb_interrupt_arbiter;

  localparam int NUM_CH = 3;
  localparam int IDX_W  = 2;

  logic              phi1 = 1'b0;
  logic              rstAll;
  logic [NUM_CH-1:0] intIn_L;
  logic [NUM_CH-1:0] maskEn;
  logic              intHandled;
  logic              clrOverrun;
  logic [IDX_W-1:0]  activeInt;
  logic              intValid;
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] overrun;

  int n_checks = 0;
  int n_pass   = 0;

  logic [IDX_W-1:0] exp_q[$];
  logic [IDX_W-1:0] exp_idx;
  logic             prev_valid = 1'b0;

  always #5 phi1 = ~phi1;

  interrupt_arbiter #(
    .NUM_CH     (3),
    .IDX_W      (2),
    .EDGE_MASK  (3'b010),
    .NOMASK     (3'b011),
    .SYNC_STAGES(2)
  ) dut (
    .phi1      (phi1),
    .rstAll    (rstAll),
    .intIn_L   (intIn_L),
    .maskEn    (maskEn),
    .intHandled(intHandled),
    .clrOverrun(clrOverrun),
    .activeInt (activeInt),
    .intValid  (intValid),
    .pending   (pending),
    .overrun   (overrun)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Advance past the next rising edge; outputs are then stable for sampling
  // and inputs written here are sampled by the following edge.
  task automatic tick();
    @(posedge phi1);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Grant monitor: every new presentation must match the next queued grant.
  always @(negedge phi1) begin
    if (!rstAll && intValid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_grant", 32'(activeInt), 32'd0);
      end else begin
        exp_idx = exp_q.pop_front();
        check("grant_index", 32'(activeInt), 32'(exp_idx));
      end
    end
    prev_valid = intValid;
  end

  // Watchdog: the directed sequence is short; anything this long is a hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstAll     = 1'b1;
    intIn_L    = '1;
    maskEn     = '0;
    intHandled = 1'b0;
    clrOverrun = 1'b0;
    tick_n(3);
    check("rst_active",  32'(activeInt), 32'd0);
    check("rst_valid",   32'(intValid),  32'd0);
    check("rst_pending", 32'(pending),   32'd0);
    check("rst_overrun", 32'(overrun),   32'd0);
    rstAll = 1'b0;
    tick_n(3);
    check("idle_pending", 32'(pending), 32'd0);

    // ---- single fall on ch1 (edge) ------------------------------------------
    intIn_L[1] = 1'b0;
    exp_q.push_back(2'd2);
    tick();                                          // edge n
    check("t1_pend_n",   32'(pending), 32'd0);
    tick();                                          // n+1
    check("t1_pend_n1",  32'(pending), 32'd0);
    tick();                                          // n+2
    check("t1_pend_n2",  32'(pending), 32'b010);
    check("t1_valid_n2", 32'(intValid), 32'd0);
    tick();                                          // n+3
    check("t1_active",   32'(activeInt), 32'd2);
    check("t1_valid",    32'(intValid),  32'd1);
    intIn_L[1] = 1'b1;
    tick_n(2);
    check("t1_hold",     32'(activeInt), 32'd2);
    intHandled = 1'b1;
    tick();                                          // edge m
    intHandled = 1'b0;
    check("t1_ack_active", 32'(activeInt), 32'd0);
    check("t1_ack_valid",  32'(intValid),  32'd0);
    check("t1_ack_pend",   32'(pending),   32'd0);
    tick_n(4);
    check("t1_quiet",      32'(intValid),  32'd0);

    // ---- ch2 level, masked then unmasked ------------------------------------
    intIn_L[2] = 1'b0;
    tick_n(3);
    check("t2_pend",        32'(pending),  32'b100);
    check("t2_masked",      32'(intValid), 32'd0);
    tick_n(3);
    check("t2_masked_hold", 32'(intValid), 32'd0);
    maskEn[2] = 1'b1;
    exp_q.push_back(2'd3);
    tick();
    check("t2_unmask_grant", 32'(activeInt), 32'd3);
    exp_q.push_back(2'd3);
    intHandled = 1'b1;
    tick();
    intHandled = 1'b0;
    check("t2_gap_valid",    32'(intValid),  32'd0);
    check("t2_gap_active",   32'(activeInt), 32'd0);
    tick();
    check("t2_regrant",      32'(activeInt), 32'd3);
    check("t2_regrant_v",    32'(intValid),  32'd1);

    // ---- no preemption: ch0 arrives while ch2 is granted --------------------
    intIn_L[0] = 1'b0;
    exp_q.push_back(2'd1);
    tick_n(5);
    check("t3_pend",       32'(pending),   32'b101);
    check("t3_no_preempt", 32'(activeInt), 32'd3);
    intHandled = 1'b1;
    tick();
    intHandled = 1'b0;
    check("t3_gap",        32'(activeInt), 32'd0);
    tick();
    check("t3_ch0_grant",  32'(activeInt), 32'd1);
    intIn_L[0] = 1'b1;
    intIn_L[2] = 1'b1;
    maskEn     = '0;
    tick_n(3);                                       // release r .. r+2
    check("t3_level_drop", 32'(pending),   32'd0);
    check("t3_grant_held", 32'(activeInt), 32'd1);
    intHandled = 1'b1;
    tick();
    intHandled = 1'b0;
    check("t3_ack",        32'(intValid),  32'd0);
    tick_n(3);
    check("t3_quiet",      32'(intValid),  32'd0);

    // ---- overrun on ch1 -----------------------------------------------------
    intIn_L[1] = 1'b0;
    exp_q.push_back(2'd2);
    tick_n(4);
    check("t4_grant",      32'(activeInt), 32'd2);
    intIn_L[1] = 1'b1;
    tick_n(3);
    intIn_L[1] = 1'b0;
    tick_n(2);
    check("t4_ovr_before", 32'(overrun),   32'd0);
    tick();
    check("t4_ovr_set",    32'(overrun),   32'b010);
    check("t4_pend",       32'(pending),   32'b010);
    check("t4_active",     32'(activeInt), 32'd2);
    clrOverrun = 1'b1;
    tick();
    clrOverrun = 1'b0;
    check("t4_ovr_clr",    32'(overrun),   32'd0);
    intIn_L[1] = 1'b1;
    tick_n(3);
    intIn_L[1] = 1'b0;
    tick_n(2);
    check("t4_ovr_pre2",   32'(overrun),   32'd0);
    clrOverrun = 1'b1;                               // coincides with new fall
    tick();
    clrOverrun = 1'b0;
    check("t4_set_wins",   32'(overrun),   32'b010);
    tick();
    check("t4_sticky",     32'(overrun),   32'b010);
    clrOverrun = 1'b1;
    tick();
    clrOverrun = 1'b0;
    check("t4_ovr_clr2",   32'(overrun),   32'd0);

    // ---- fall coincides with acknowledge of the same channel ----------------
    intIn_L[1] = 1'b1;
    tick_n(3);
    intIn_L[1] = 1'b0;
    tick_n(2);
    intHandled = 1'b1;
    exp_q.push_back(2'd2);
    tick();                                          // fall and ack together
    intHandled = 1'b0;
    check("t5_pend_kept",  32'(pending),   32'b010);
    check("t5_no_ovr",     32'(overrun),   32'd0);
    check("t5_gap",        32'(intValid),  32'd0);
    tick();
    check("t5_regrant",    32'(activeInt), 32'd2);
    intHandled = 1'b1;
    tick();
    intHandled = 1'b0;
    check("t5_ack_pend",   32'(pending),   32'd0);
    check("t5_ack_valid",  32'(intValid),  32'd0);
    tick_n(3);
    check("t5_quiet",      32'(intValid),  32'd0);

    // ---- asynchronous reset mid-grant ---------------------------------------
    intIn_L[1] = 1'b1;
    tick_n(3);
    intIn_L[1] = 1'b0;
    exp_q.push_back(2'd2);
    tick_n(4);
    check("t6_grant",      32'(activeInt), 32'd2);
    intIn_L[0] = 1'b0;
    tick_n(3);
    check("t6_pend",       32'(pending),   32'b011);
    #2;
    rstAll = 1'b1;                                   // between clock edges
    #1;
    check("t6_async_active",  32'(activeInt), 32'd0);
    check("t6_async_valid",   32'(intValid),  32'd0);
    check("t6_async_pending", 32'(pending),   32'd0);
    check("t6_async_overrun", 32'(overrun),   32'd0);
    intIn_L[1] = 1'b1;                               // ch1 quiet, ch0 held low
    tick_n(2);
    rstAll = 1'b0;
    exp_q.push_back(2'd1);
    tick_n(2);
    check("t6_pend_early", 32'(pending),   32'd0);
    tick();
    check("t6_pend_ch0",   32'(pending),   32'b001);
    tick();
    check("t6_regrant",    32'(activeInt), 32'd1);
    check("t6_regrant_v",  32'(intValid),  32'd1);
    intIn_L[0] = 1'b1;
    tick_n(3);
    check("t6_pend_drop",  32'(pending),   32'd0);
    intHandled = 1'b1;
    tick();
    intHandled = 1'b0;
    check("t6_ack",        32'(activeInt), 32'd0);
    tick_n(3);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
